muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 149 ++++++++++++++
 tb/tb_muldiv_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Sequential 32-bit multiply/divide unit with HI/LO result registers.
// Multiplies by shift-add and divides by restoring shift-subtract, one bit per cycle.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  localparam logic [2:0] OP_MULTU = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_div;
  logic          neg_lo;
  logic          neg_hi;
  logic [W-1:0]  mag_b;
  logic [W-1:0]  acc;
  logic [W-1:0]  shr;

  logic [W-1:0]   abs_x;
  logic [W-1:0]   abs_y;
  logic [W:0]     mul_sum;
  logic           div_ge;
  logic [W-1:0]   div_rem;
  logic [2*W-1:0] prod_fix;

  assign busy = (state != S_IDLE);

  // Operand magnitudes and one iteration step of each datapath
  always_comb begin
    abs_x    = (op[0] && X[W-1]) ? W'(-X) : X;
    abs_y    = (op[0] && Y[W-1]) ? W'(-Y) : Y;
    mul_sum  = {1'b0, acc} + (shr[0] ? {1'b0, mag_b} : (W+1)'(0));
    div_ge   = ({acc, shr[W-1]} >= {1'b0, mag_b});
    div_rem  = W'({acc[W-2:0], shr[W-1]} - mag_b);
    prod_fix = neg_lo ? (2*W)'(-{acc, shr}) : {acc, shr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      mag_b    <= '0;
      acc      <= '0;
      shr      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULTU, OP_MULT: begin
                state  <= S_MUL;
                cnt    <= '0;
                is_div <= 1'b0;
                neg_lo <= op[0] & (X[W-1] ^ Y[W-1]);
                neg_hi <= 1'b0;
                mag_b  <= abs_x;
                shr    <= abs_y;
                acc    <= '0;
              end
              OP_DIVU, OP_DIV: begin
                if (Y == '0) begin
                  done     <= 1'b1;
                  div_zero <= 1'b1;
                end else begin
                  state  <= S_DIV;
                  cnt    <= '0;
                  is_div <= 1'b1;
                  neg_lo <= op[0] & (X[W-1] ^ Y[W-1]);
                  neg_hi <= op[0] & X[W-1];
                  mag_b  <= abs_y;
                  shr    <= abs_x;
                  acc    <= '0;
                end
              end
              OP_MTHI: begin
                HI   <= X;
                done <= 1'b1;
              end
              OP_MTLO: begin
                LO   <= X;
                done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        // {acc,shr} is the partial product shifted right; shr holds remaining multiplier bits
        S_MUL: begin
          acc <= mul_sum[W:1];
          shr <= {mul_sum[0], shr[W-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W-1)) state <= S_FIN;
        end
        // acc is the partial remainder; dividend bits shift out of shr as quotient bits shift in
        S_DIV: begin
          if (div_ge) begin
            acc <= div_rem;
            shr <= {shr[W-2:0], 1'b1};
          end else begin
            acc <= {acc[W-2:0], shr[W-1]};
            shr <= {shr[W-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W-1)) state <= S_FIN;
        end
        S_FIN: begin
          if (is_div) begin
            LO <= neg_lo ? W'(-shr) : shr;
            HI <= neg_hi ? W'(-acc) : acc;
          end else begin
            {HI, LO} <= prod_fix;
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] X = 32'd0;
  logic [31:0] Y = 32'd0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  localparam int LIMIT = 60;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .X(X), .Y(Y),
    .busy(busy), .done(done), .div_zero(div_zero), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: latency (-1 = ignored op), div_zero flag and resulting HI/LO
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output logic dz, output logic [31:0] nh,
                       output logic [31:0] nl);
    logic [63:0] p;
    longint sx, sy, q, r;
    nh = exp_hi; nl = exp_lo; dz = 1'b0; lat = -1;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = {32'd0, x} * {32'd0, y}; nh = p[63:32]; nl = p[31:0]; lat = 33; end
      3'd1: begin p = sx * sy; nh = p[63:32]; nl = p[31:0]; lat = 33; end
      3'd2, 3'd3: begin
        if (y == 32'd0) begin
          lat = 0; dz = 1'b1;
        end else if (o == 3'd2) begin
          nl = x / y; nh = x % y; lat = 33;
        end else begin
          q = sx / sy; r = sx % sy;
          nl = 32'(q); nh = 32'(r); lat = 33;
        end
      end
      3'd4: begin nh = x; lat = 0; end
      3'd5: begin nl = x; lat = 0; end
      default: ;
    endcase
  endtask

  // Issue one op from the current negedge and check its whole lifetime
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input bit poke);
    int lat, n;
    logic dz, busy_ok, stable, exp_busy;
    logic [31:0] nh, nl;
    model(o, x, y, lat, dz, nh, nl);
    exp_busy = (lat > 0);
    op = o; X = x; Y = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    X = $urandom; Y = $urandom; op = 3'($urandom);
    n = 0; busy_ok = 1'b1; stable = 1'b1;
    while (done !== 1'b1 && n < LIMIT) begin
      if (busy !== exp_busy) busy_ok = 1'b0;
      if (HI !== exp_hi || LO !== exp_lo) stable = 1'b0;
      start = (poke && lat > 0 && n == 5);
      if (start) op = 3'($urandom);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, ".latency"}, 64'(n), 64'(lat < 0 ? LIMIT : lat));
    chk({tag, ".busy"}, 64'(busy_ok), 64'(1));
    chk({tag, ".hold"}, 64'(stable), 64'(1));
    if (lat >= 0) begin
      exp_hi = nh; exp_lo = nl;
      chk({tag, ".div_zero"}, 64'(div_zero), 64'(dz));
      chk({tag, ".busy_at_done"}, 64'(busy), 64'(0));
    end
    chk({tag, ".HI"}, 64'(HI), 64'(exp_hi));
    chk({tag, ".LO"}, 64'(LO), 64'(exp_lo));
  endtask

  initial begin
    logic saw_done;
    logic [2:0] ro;
    logic [31:0] rx, ry;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset.busy", 64'(busy), 64'(0));
    chk("reset.done", 64'(done), 64'(0));
    chk("reset.div_zero", 64'(div_zero), 64'(0));
    chk("reset.HI", 64'(HI), 64'(0));
    chk("reset.LO", 64'(LO), 64'(0));
    rst = 1'b0;

    do_op("mult_neg3x5", 3'd1, 32'hFFFFFFFD, 32'd5, 1'b1);
    chk("mult_neg3x5.HI_const", 64'(HI), 64'hFFFFFFFF);
    chk("mult_neg3x5.LO_const", 64'(LO), 64'hFFFFFFF1);
    do_op("multu_max", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("multu_max.HI_const", 64'(HI), 64'hFFFFFFFE);
    chk("multu_max.LO_const", 64'(LO), 64'h00000001);
    do_op("divu_100_7", 3'd2, 32'd100, 32'd7, 1'b1);
    chk("divu_100_7.LO_const", 64'(LO), 64'd14);
    chk("divu_100_7.HI_const", 64'(HI), 64'd2);
    do_op("div_m7_2", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div_m7_2.LO_const", 64'(LO), 64'hFFFFFFFD);
    chk("div_m7_2.HI_const", 64'(HI), 64'hFFFFFFFF);
    do_op("div_min_m1", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("div_min_m1.LO_const", 64'(LO), 64'h80000000);
    chk("div_min_m1.HI_const", 64'(HI), 64'd0);

    do_op("mthi", 3'd4, 32'h0000AAAA, 32'd0, 1'b0);
    do_op("mtlo", 3'd5, 32'h00005555, 32'd0, 1'b0);
    do_op("div_by_zero", 3'd3, 32'd99, 32'd0, 1'b0);
    chk("div_by_zero.HI_const", 64'(HI), 64'h0000AAAA);
    chk("div_by_zero.LO_const", 64'(LO), 64'h00005555);
    @(negedge clk);
    chk("div_by_zero.done_once", 64'(done), 64'(0));
    chk("div_by_zero.dz_once", 64'(div_zero), 64'(0));
    do_op("reserved6", 3'd6, 32'h12345678, 32'd1, 1'b0);
    do_op("reserved7", 3'd7, 32'h12345678, 32'd1, 1'b0);

    // Abort a running multiply with reset; an in-flight start must be ignored
    op = 3'd1; X = 32'd3; Y = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (done === 1'b1) saw_done = 1'b1;
      start = (k == 2);
      if (k == 2) begin op = 3'd2; X = 32'd100; Y = 32'd7; end
      if (k == 8) chk("abort.busy_before", 64'(busy), 64'(1));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort.busy", 64'(busy), 64'(0));
    chk("abort.HI", 64'(HI), 64'(0));
    chk("abort.LO", 64'(LO), 64'(0));
    chk("abort.no_done", 64'(saw_done | done), 64'(0));
    exp_hi = 32'd0; exp_lo = 32'd0;
    rst = 1'b0;
    do_op("after_rst_multu", 3'd0, 32'd2, 32'd3, 1'b0);
    chk("after_rst_multu.LO_const", 64'(LO), 64'd6);
    do_op("b2b_mtlo", 3'd5, 32'h00001234, 32'd0, 1'b0);
    chk("b2b_mtlo.LO_const", 64'(LO), 64'h1234);

    // Reset wins over a simultaneous start
    rst = 1'b1; start = 1'b1; op = 3'd5; X = 32'h0000DEAD;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_prio.LO", 64'(LO), 64'(0));
    chk("rst_prio.done", 64'(done), 64'(0));
    exp_lo = 32'd0;

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'd0;
        1: rx = 32'h80000000;
        2: ry = 32'hFFFFFFFF;
        3: ry = 32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op("rand", ro, rx, ry, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        chk("rand.done_once", 64'(done), 64'(0));
        chk("rand.dz_once", 64'(div_zero), 64'(0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
